// File: rtl/scsi_dma_sm_if.sv
// -----------------------------------------------------------------------------
// scsi_dma_sm_if
// Bundles the SCSI-side DMA handshake, FIFO status/pointer inputs and the
// strobe/pointer-pulse outputs of the SCSI byte sequencer.
//   slave  : the sequencer (scsi_dma_sm) side
//   master : the environment (SCSI controller + FIFO) side
// Optional macro SCSI_DMA_FLUSH_EN adds FLUSH (in) / FLUSHED (out).
// -----------------------------------------------------------------------------
interface scsi_dma_sm_if;
    // Environment -> sequencer
    logic        DMAENA;     // DMA enabled
    logic        DMADIR;     // 1 = memory->SCSI, 0 = SCSI->memory
    logic        DREQ_;      // DMA request, active low
    logic        FIFOFULL;   // FIFO full flag
    logic        FIFOEMPTY;  // FIFO empty flag
    logic        BOEQ3;      // byte pointer at 4th byte
    logic        BO0;        // byte pointer bit 0
    logic        BO1;        // byte pointer bit 1
    logic [31:0] FIFO_OD;    // FIFO read data
    // Sequencer -> environment
    logic        DACK_;      // DMA acknowledge, active low
    logic        RE_;        // SCSI read strobe, active low
    logic        WE_;        // SCSI write strobe, active low
    logic [7:0]  SCSI_DO;    // byte to SCSI controller
    logic        LBYTE_;     // load byte strobe to FIFO, active low
    logic        INCBO;      // increment byte pointer
    logic        INCNI;      // increment FIFO write pointer
    logic        INCNO;      // increment FIFO read pointer
    logic        INCFIFO;    // longword added to FIFO
    logic        DECFIFO;    // longword removed from FIFO
    logic        BUSY;       // transfer in progress
`ifdef SCSI_DMA_FLUSH_EN
    logic        FLUSH;      // commit partial longword request
    logic        FLUSHED;    // flush completed pulse
`endif

    modport slave (
        input  DMAENA, DMADIR, DREQ_, FIFOFULL, FIFOEMPTY, BOEQ3, BO0, BO1, FIFO_OD,
`ifdef SCSI_DMA_FLUSH_EN
        input  FLUSH,
        output FLUSHED,
`endif
        output DACK_, RE_, WE_, SCSI_DO, LBYTE_, INCBO, INCNI, INCNO, INCFIFO,
               DECFIFO, BUSY
    );

    modport master (
        output DMAENA, DMADIR, DREQ_, FIFOFULL, FIFOEMPTY, BOEQ3, BO0, BO1, FIFO_OD,
`ifdef SCSI_DMA_FLUSH_EN
        output FLUSH,
        input  FLUSHED,
`endif
        input  DACK_, RE_, WE_, SCSI_DO, LBYTE_, INCBO, INCNI, INCNO, INCFIFO,
               DECFIFO, BUSY
    );
endinterface

// File: rtl/scsi_dma_sm.sv
// -----------------------------------------------------------------------------
// scsi_dma_sm
// SCSI-side byte transfer sequencer in front of the 8x32 FIFO. Runs the
// DREQ_/DACK_ handshake one byte at a time:
//   SCSI->memory (DMADIR=0): RE_ strobe, LBYTE_ in the last strobe cycle.
//   memory->SCSI (DMADIR=1): WE_ strobe, SCSI_DO = FIFO_OD byte picked by BO.
// Each byte ends with an INCBO pulse; the 4th byte of a longword also pulses
// INCNI+INCFIFO (write) or INCNO+DECFIFO (read).
// Ports:
//   CLK   system clock
//   RST_  asynchronous active-low reset
//   bus   scsi_dma_sm_if.slave (handshake, FIFO status, strobes, pulses)
// Parameters:
//   STROBE_CYCLES  RE_/WE_ low width in cycles (1..15)
//   RECOVER_CYCLES idle gap after each byte (0..15)
// Optional macro SCSI_DMA_FLUSH_EN: adds FLUSH/FLUSHED to commit a partial
// longword to the FIFO.
// All outputs are registered.
// -----------------------------------------------------------------------------
module scsi_dma_sm #(
    parameter int STROBE_CYCLES  = 2,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST_,
    scsi_dma_sm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STRB = 3'd1,
        DONE = 3'd2,
        RCVR = 3'd3,
        FLSH = 3'd4    // only reachable with SCSI_DMA_FLUSH_EN
    } state_t;

    localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] RCVR_LAST = 4'((RECOVER_CYCLES > 0) ? RECOVER_CYCLES - 1 : 0);
    localparam bit         HAS_RCVR  = (RECOVER_CYCLES > 0);
    // With a single strobe cycle the entry cycle is also the last one.
    localparam bit         ONE_STRB  = (STROBE_CYCLES == 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        dir;       // DMADIR captured at start
    logic        last_lw;   // BOEQ3 captured at start: this byte closes a longword
    logic [7:0]  sel_byte;
    logic        start;

    // Big-endian byte lane selection: pointer 0 is the MSB of the longword.
    always_comb begin
        sel_byte = bus.FIFO_OD[31:24];
        case ({bus.BO1, bus.BO0})
            2'b00:   sel_byte = bus.FIFO_OD[31:24];
            2'b01:   sel_byte = bus.FIFO_OD[23:16];
            2'b10:   sel_byte = bus.FIFO_OD[15:8];
            default: sel_byte = bus.FIFO_OD[7:0];
        endcase
    end

    assign start = bus.DMAENA & ~bus.DREQ_ &
                   (bus.DMADIR ? ~bus.FIFOEMPTY : ~bus.FIFOFULL);

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            dir         <= 1'b0;
            last_lw     <= 1'b0;
            bus.DACK_   <= 1'b1;
            bus.RE_     <= 1'b1;
            bus.WE_     <= 1'b1;
            bus.LBYTE_  <= 1'b1;
            bus.SCSI_DO <= 8'h00;
            bus.INCBO   <= 1'b0;
            bus.INCNI   <= 1'b0;
            bus.INCNO   <= 1'b0;
            bus.INCFIFO <= 1'b0;
            bus.DECFIFO <= 1'b0;
            bus.BUSY    <= 1'b0;
`ifdef SCSI_DMA_FLUSH_EN
            bus.FLUSHED <= 1'b0;
`endif
        end else begin
            // Pointer pulses are single-cycle: cleared unless set below.
            bus.INCBO   <= 1'b0;
            bus.INCNI   <= 1'b0;
            bus.INCNO   <= 1'b0;
            bus.INCFIFO <= 1'b0;
            bus.DECFIFO <= 1'b0;
`ifdef SCSI_DMA_FLUSH_EN
            bus.FLUSHED <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef SCSI_DMA_FLUSH_EN
                    // Flush wins over a start in the same cycle.
                    if (bus.FLUSH) begin
                        state    <= FLSH;
                        bus.BUSY <= 1'b1;
                        if (!bus.DMADIR && ({bus.BO1, bus.BO0} != 2'b00)) begin
                            bus.INCNI   <= 1'b1;
                            bus.INCFIFO <= 1'b1;
                        end
                    end else
`endif
                    if (start) begin
                        state       <= STRB;
                        cnt         <= 4'd0;
                        dir         <= bus.DMADIR;
                        last_lw     <= bus.BOEQ3;
                        bus.SCSI_DO <= sel_byte;
                        bus.DACK_   <= 1'b0;
                        bus.RE_     <= bus.DMADIR;
                        bus.WE_     <= ~bus.DMADIR;
                        bus.LBYTE_  <= bus.DMADIR | ~ONE_STRB;
                        bus.BUSY    <= 1'b1;
                    end
                end

                STRB: begin
                    if (cnt == STRB_LAST) begin
                        state      <= DONE;
                        bus.DACK_  <= 1'b1;
                        bus.RE_    <= 1'b1;
                        bus.WE_    <= 1'b1;
                        bus.LBYTE_ <= 1'b1;
                        bus.INCBO  <= 1'b1;
                        if (last_lw) begin
                            if (dir) begin
                                bus.INCNO   <= 1'b1;
                                bus.DECFIFO <= 1'b1;
                            end else begin
                                bus.INCNI   <= 1'b1;
                                bus.INCFIFO <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                        // Entering the final strobe cycle: load the FIFO lane.
                        if (!dir && (cnt + 4'd1 == STRB_LAST))
                            bus.LBYTE_ <= 1'b0;
                    end
                end

                DONE: begin
                    if (HAS_RCVR) begin
                        state <= RCVR;
                        cnt   <= 4'd0;
                    end else begin
                        state    <= IDLE;
                        bus.BUSY <= 1'b0;
                    end
                end

                RCVR: begin
                    if (cnt == RCVR_LAST) begin
                        state    <= IDLE;
                        bus.BUSY <= 1'b0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                FLSH: begin
`ifdef SCSI_DMA_FLUSH_EN
                    bus.FLUSHED <= 1'b1;
`endif
                    state    <= IDLE;
                    bus.BUSY <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    bus.BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/scsi_dma_sm.md
Name: scsi_dma_sm

Overview:
SCSI-side byte transfer sequencer that sits directly upstream and downstream of the 8x32 FIFO. It runs the DREQ_/DACK_ handshake with the SCSI controller, one byte per transfer.
- SCSI->memory: strobes each byte into the FIFO lane chosen by the byte pointer.
- Memory->SCSI: drives the selected FIFO output byte onto the SCSI data bus.
- In both directions it advances the byte pointer and, on every 4th byte, the longword pointer and the full/empty count.

Parameters:
STROBE_CYCLES, 2, width of RE_/WE_ low pulse in CLK cycles (legal 1..15)
RECOVER_CYCLES, 1, idle gap after each byte before next DREQ_ is honoured (legal 0..15)

Ports:
CLK  in  1  system clock
RST_  in  1  asynchronous active-low reset
DMAENA  in  1  DMA enabled
DMADIR  in  1  1 = memory->SCSI (FIFO read), 0 = SCSI->memory (FIFO write)
DREQ_  in  1  SCSI controller DMA request, active low
FIFOFULL  in  1  FIFO full flag
FIFOEMPTY  in  1  FIFO empty flag
BOEQ3  in  1  byte pointer at 4th byte
BO0  in  1  byte pointer bit 0
BO1  in  1  byte pointer bit 1
FIFO_OD  in  32  FIFO read data
DACK_  out  1  DMA acknowledge to SCSI controller, active low
RE_  out  1  SCSI read strobe, active low
WE_  out  1  SCSI write strobe, active low
SCSI_DO  out  8  byte to SCSI controller
LBYTE_  out  1  load byte strobe to FIFO, active low
INCBO  out  1  increment byte pointer
INCNI  out  1  increment FIFO write pointer
INCNO  out  1  increment FIFO read pointer
INCFIFO  out  1  longword added to FIFO
DECFIFO  out  1  longword removed from FIFO
BUSY  out  1  transfer in progress (state != IDLE)

Behaviour:
- All outputs are registered.
- Reset values:
  - DACK_=RE_=WE_=LBYTE_=1
  - INCBO=INCNI=INCNO=INCFIFO=DECFIFO=0
  - SCSI_DO=8'h00, BUSY=0
  - state IDLE, counter 0
- States: IDLE, STRB, DONE, RCVR.
- Start condition, evaluated in IDLE: DMAENA & ~DREQ_ & (DMADIR ? ~FIFOEMPTY : ~FIFOFULL). If true, next cycle is STRB. DMADIR is latched at start and held for the whole byte.
- STRB lasts STROBE_CYCLES cycles.
  - DACK_=0 throughout.
  - DMADIR=0: RE_=0, and LBYTE_=0 only during the last STRB cycle.
  - DMADIR=1: WE_=0.
  - SCSI_DO is latched on STRB entry from the FIFO_OD byte selected by {BO1,BO0}: 00->[31:24], 01->[23:16], 10->[15:8], 11->[7:0]. It is held until the next latch.
- DONE lasts 1 cycle.
  - DACK_, RE_, WE_, LBYTE_ are all high; INCBO=1.
  - If BOEQ3 was high on STRB entry:
    - DMADIR=0: INCNI=1 and INCFIFO=1.
    - DMADIR=1: INCNO=1 and DECFIFO=1.
  - All pulses are exactly 1 cycle.
- After DONE:
  - RECOVER_CYCLES>0: RCVR for RECOVER_CYCLES cycles, then IDLE.
  - RECOVER_CYCLES=0: straight to IDLE.
- Latency: DREQ_ low with FIFO ready -> DACK_ low after 1 CLK. Per-byte period = 1 + STROBE_CYCLES + 1 + RECOVER_CYCLES cycles.
- DMAENA or DREQ_ deasserted mid-byte: the current byte completes (no abort); no new start.
- FIFOFULL/FIFOEMPTY are checked only at start. Once started, a byte always completes.
- Reset mid-operation: all strobes go inactive asynchronously; no pointer pulse is issued.
- INCNI and INCNO are never asserted in the same cycle.

Optional Feature:
Macro: SCSI_DMA_FLUSH_EN.
- With the macro: input FLUSH (1) and output FLUSHED (1) are added.
  - FLUSH high in IDLE, with DMADIR=0 and byte pointer != 0, issues one cycle with INCNI=1, INCFIFO=1 and INCBO=0. This commits the partial longword.
  - FLUSHED pulses 1 cycle afterwards.
  - With byte pointer == 0, FLUSH only pulses FLUSHED.
  - FLUSH has priority over a simultaneous start condition.
- Without the macro: neither port exists, and partial longwords stay uncommitted.

Test Plan:
- Reset: hold RST_=0 -> DACK_=RE_=WE_=LBYTE_=1, all pulses 0, BUSY=0, SCSI_DO=00.
- SCSI->mem, defaults, 4 bytes via DREQ_ low, BO stepping 0..3 -> per byte: DACK_/RE_ low 2 cycles, LBYTE_ low in the 2nd, INCBO 1 cycle. Only the 4th byte also pulses INCNI+INCFIFO. Period 5 cycles.
- Mem->SCSI, FIFO_OD=32'hA1B2C3D4, BO 0..3 -> SCSI_DO = A1, B2, C3, D4. WE_ low 2 cycles each; INCNO+DECFIFO on byte 4 only.
- Boundaries: FIFOFULL=1 with DMADIR=0, or FIFOEMPTY=1 with DMADIR=1, and DREQ_ low -> remains IDLE, DACK_=1. Clear the flag -> DACK_ low next cycle.
- Mid-byte: DREQ_ released after the 1st STRB cycle -> byte completes normally. RST_ low during STRB -> strobes high immediately, no INCBO.
- With SCSI_DMA_FLUSH_EN: 2 bytes written, then FLUSH -> single INCNI+INCFIFO pulse, INCBO=0, FLUSHED next cycle.
